// File: rtl/execute.sv
// Execute stage and EX/MEM pipeline register.
// Computes an ALU result, or a 32x32 multiply (low 32 bits) over 32 shift-add
// steps, and latches result plus control into the EX/MEM register under the
// ihit/dhit/flush advance rules shared with the memory stage.
module execute (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        flush,
    input  logic [31:0] rdat1,
    input  logic [31:0] rdat2,
    input  logic [31:0] imm,
    input  logic [4:0]  shamt,
    input  logic        aluSrc,
    input  logic [3:0]  aluOp,
    input  logic        mulEn,
    input  logic        mulSigned,
    input  logic [31:0] nPC,
    input  logic        regWr,
    input  logic [1:0]  regSel,
    input  logic [4:0]  regDst,
    input  logic        dREN,
    input  logic        dWEN,
    output logic        busy,
    output logic [31:0] ALUOut_next,
    output logic [31:0] dmemstore_next,
    output logic [31:0] nPC_next,
    output logic        regWr_next,
    output logic [1:0]  regSel_next,
    output logic [4:0]  regDst_next,
    output logic        dREN_next,
    output logic        dWEN_next
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } mstate_e;

    typedef struct packed {
        logic [31:0] aluout;
        logic [31:0] dmemstore;
        logic [31:0] npc;
        logic        regwr;
        logic [1:0]  regsel;
        logic [4:0]  regdst;
        logic        dren;
        logic        dwen;
    } exmem_t;

    // ALU operation codes
    localparam logic [3:0] OP_SLL  = 4'd0;
    localparam logic [3:0] OP_SRL  = 4'd1;
    localparam logic [3:0] OP_SRA  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_NOR  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;
    localparam logic [3:0] OP_LUI  = 4'd11;

    logic [31:0] opb;
    logic [31:0] alu_res;

    mstate_e     state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic [31:0] product;

    exmem_t      exmem_q, exmem_d;
    logic        advance;

    // ALU: B operand select and combinational result
    always_comb begin
        opb     = aluSrc ? imm : rdat2;
        alu_res = 32'd0;
        case (aluOp)
            OP_SLL:  alu_res = opb << shamt;
            OP_SRL:  alu_res = opb >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(opb) >>> shamt);
            OP_ADD:  alu_res = rdat1 + opb;
            OP_SUB:  alu_res = rdat1 - opb;
            OP_AND:  alu_res = rdat1 & opb;
            OP_OR:   alu_res = rdat1 | opb;
            OP_XOR:  alu_res = rdat1 ^ opb;
            OP_NOR:  alu_res = ~(rdat1 | opb);
            OP_SLT:  alu_res = {31'd0, $signed(rdat1) < $signed(opb)};
            OP_SLTU: alu_res = {31'd0, rdat1 < opb};
            OP_LUI:  alu_res = {opb[15:0], 16'h0000};
            default: alu_res = 32'd0;
        endcase
    end

    // Multiplier next-state: capture magnitudes, 32 shift-add steps, hold result
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        case (state_q)
            S_IDLE: begin
                if (mulEn) begin
                    mcand_d  = (mulSigned && rdat1[31]) ? (~rdat1 + 32'd1) : rdat1;
                    mplier_d = (mulSigned && rdat2[31]) ? (~rdat2 + 32'd1) : rdat2;
                    neg_d    = mulSigned && (rdat1[31] ^ rdat2[31]);
                    acc_d    = 32'd0;
                    cnt_d    = 5'd0;
                    state_d  = S_MUL;
                end
            end
            S_MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Leave only when the product is actually latched; a dhit on
                // the same edge blocks the load, so the result must stay held.
                if (ihit && !dhit) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    // Multiplier state and datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            acc_q    <= 32'd0;
            cnt_q    <= 5'd0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
        end
    end

    // Signed result is the magnitude product negated when operand signs differ
    assign product = neg_q ? (~acc_q + 32'd1) : acc_q;
    assign busy    = ((state_q == S_IDLE) && mulEn) || (state_q == S_MUL);
    assign advance = ihit && !busy;

    // EX/MEM next value: flush clears, dhit retires the memory request, ihit loads
    always_comb begin
        exmem_d = exmem_q;
        if (flush) begin
            exmem_d = '0;
        end else if (dhit) begin
            exmem_d.dren = 1'b0;
            exmem_d.dwen = 1'b0;
        end else if (advance) begin
            exmem_d.aluout    = (state_q == S_DONE) ? product : alu_res;
            exmem_d.dmemstore = rdat2;
            exmem_d.npc       = nPC;
            exmem_d.regwr     = regWr;
            exmem_d.regsel    = regSel;
            exmem_d.regdst    = regDst;
            exmem_d.dren      = dREN;
            exmem_d.dwen      = dWEN;
        end
    end

    // EX/MEM pipeline register
    always_ff @(posedge CLK) begin
        if (RST) begin
            exmem_q <= '0;
        end else begin
            exmem_q <= exmem_d;
        end
    end

    assign ALUOut_next    = exmem_q.aluout;
    assign dmemstore_next = exmem_q.dmemstore;
    assign nPC_next       = exmem_q.npc;
    assign regWr_next     = exmem_q.regwr;
    assign regSel_next    = exmem_q.regsel;
    assign regDst_next    = exmem_q.regdst;
    assign dREN_next      = exmem_q.dren;
    assign dWEN_next      = exmem_q.dwen;

endmodule

// File: tb/tb_execute.sv
// Directed testbench for the execute stage / EX/MEM register.
module tb_execute;

    logic        CLK = 1'b0;
    logic        RST, ihit, dhit, flush;
    logic [31:0] rdat1, rdat2, imm, nPC;
    logic [4:0]  shamt, regDst;
    logic        aluSrc, mulEn, mulSigned, regWr, dREN, dWEN;
    logic [3:0]  aluOp;
    logic [1:0]  regSel;
    logic        busy;
    logic [31:0] ALUOut_next, dmemstore_next, nPC_next;
    logic        regWr_next, dREN_next, dWEN_next;
    logic [1:0]  regSel_next;
    logic [4:0]  regDst_next;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] im;
        logic        src;
        logic [4:0]  sh;
        logic [3:0]  op;
        logic [31:0] exp;
    } alu_vec_t;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } mul_vec_t;

    always #5 CLK = ~CLK;

    execute dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .flush(flush),
        .rdat1(rdat1), .rdat2(rdat2), .imm(imm), .shamt(shamt),
        .aluSrc(aluSrc), .aluOp(aluOp), .mulEn(mulEn), .mulSigned(mulSigned),
        .nPC(nPC), .regWr(regWr), .regSel(regSel), .regDst(regDst),
        .dREN(dREN), .dWEN(dWEN), .busy(busy),
        .ALUOut_next(ALUOut_next), .dmemstore_next(dmemstore_next),
        .nPC_next(nPC_next), .regWr_next(regWr_next), .regSel_next(regSel_next),
        .regDst_next(regDst_next), .dREN_next(dREN_next), .dWEN_next(dWEN_next)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; ihit = 1'b1; dhit = 1'b0; flush = 1'b0;
        rdat1 = 32'd5; rdat2 = 32'd7; imm = 32'd0; shamt = 5'd0;
        aluSrc = 1'b0; aluOp = 4'd3; mulEn = 1'b0; mulSigned = 1'b0;
        nPC = 32'h44; regWr = 1'b1; regSel = 2'd1; regDst = 5'd4;
        dREN = 1'b1; dWEN = 1'b1;
        tick(); tick();
        n_chk++; if (ALUOut_next !== 32'd0) $display("FAIL reset_aluout got=%h exp=0", ALUOut_next); else n_pass++;
        n_chk++; if (nPC_next !== 32'd0) $display("FAIL reset_npc got=%h exp=0", nPC_next); else n_pass++;
        n_chk++; if ({regWr_next, regSel_next, regDst_next, dREN_next, dWEN_next} !== 10'd0)
            $display("FAIL reset_ctrl got=%b exp=0", {regWr_next, regSel_next, regDst_next, dREN_next, dWEN_next}); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy0 got=%b exp=0", busy); else n_pass++;
        mulEn = 1'b1; #1;
        n_chk++; if (busy !== 1'b1) $display("FAIL reset_busy_mulen got=%b exp=1", busy); else n_pass++;
        mulEn = 1'b0; ihit = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_alu();
        alu_vec_t v [0:13];
        v[0]  = '{32'd5,        32'd7,        32'd0,       1'b0, 5'd0,  4'd3,  32'd12};
        v[1]  = '{32'd0,        32'd1,        32'd0,       1'b0, 5'd0,  4'd4,  32'hFFFFFFFF};
        v[2]  = '{32'hFFFFFFFF, 32'd1,        32'd0,       1'b0, 5'd0,  4'd9,  32'd1};
        v[3]  = '{32'hFFFFFFFF, 32'd1,        32'd0,       1'b0, 5'd0,  4'd10, 32'd0};
        v[4]  = '{32'd0,        32'd0,        32'h1234,    1'b1, 5'd0,  4'd11, 32'h12340000};
        v[5]  = '{32'd0,        32'h80000000, 32'd0,       1'b0, 5'd4,  4'd2,  32'hF8000000};
        v[6]  = '{32'd0,        32'd1,        32'd0,       1'b0, 5'd31, 4'd0,  32'h80000000};
        v[7]  = '{32'd0,        32'h80000000, 32'd0,       1'b0, 5'd4,  4'd1,  32'h08000000};
        v[8]  = '{32'hF0F0,     32'hFF00,     32'd0,       1'b0, 5'd0,  4'd5,  32'hF000};
        v[9]  = '{32'hF0F0,     32'hFF00,     32'd0,       1'b0, 5'd0,  4'd6,  32'hFFF0};
        v[10] = '{32'hF0F0,     32'hFF00,     32'd0,       1'b0, 5'd0,  4'd7,  32'h0FF0};
        v[11] = '{32'd0,        32'd0,        32'd0,       1'b0, 5'd0,  4'd8,  32'hFFFFFFFF};
        v[12] = '{32'd9,        32'd9,        32'd0,       1'b0, 5'd0,  4'd12, 32'd0};
        v[13] = '{32'hFFFFFFFF, 32'd0,        32'd2,       1'b1, 5'd0,  4'd3,  32'd1};
        for (int i = 0; i < 14; i++) begin
            rdat1 = v[i].a; rdat2 = v[i].b; imm = v[i].im; aluSrc = v[i].src;
            shamt = v[i].sh; aluOp = v[i].op; ihit = 1'b1;
            tick();
            n_chk++;
            if (ALUOut_next !== v[i].exp)
                $display("FAIL alu_vec%0d op=%0d got=%h exp=%h", i, v[i].op, ALUOut_next, v[i].exp);
            else n_pass++;
        end
        ihit = 1'b0; aluSrc = 1'b0; shamt = 5'd0;
    endtask

    task automatic test_control();
        rdat1 = 32'd1; rdat2 = 32'hCAFE0001; aluOp = 4'd3;
        nPC = 32'h400; regWr = 1'b1; regSel = 2'd2; regDst = 5'd17;
        dREN = 1'b0; dWEN = 1'b1; ihit = 1'b1;
        tick();
        n_chk++; if (dmemstore_next !== 32'hCAFE0001) $display("FAIL ctl_store got=%h exp=cafe0001", dmemstore_next); else n_pass++;
        n_chk++; if (nPC_next !== 32'h400) $display("FAIL ctl_npc got=%h exp=400", nPC_next); else n_pass++;
        n_chk++; if ({regWr_next, regSel_next, regDst_next, dREN_next, dWEN_next} !== {1'b1, 2'd2, 5'd17, 1'b0, 1'b1})
            $display("FAIL ctl_fields got=%b", {regWr_next, regSel_next, regDst_next, dREN_next, dWEN_next}); else n_pass++;
        // No ihit: register holds despite new inputs
        ihit = 1'b0; nPC = 32'h800; regDst = 5'd2; rdat1 = 32'd50;
        tick();
        n_chk++; if (nPC_next !== 32'h400 || regDst_next !== 5'd17 || ALUOut_next !== 32'hCAFE0002)
            $display("FAIL ctl_hold npc=%h dst=%0d alu=%h", nPC_next, regDst_next, ALUOut_next); else n_pass++;
        dWEN = 1'b0; regWr = 1'b0; regSel = 2'd0;
    endtask

    task automatic test_multiply();
        mul_vec_t m [0:1];
        int cyc;
        m[0] = '{1'b1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB};
        m[1] = '{1'b0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE};
        for (int i = 0; i < 2; i++) begin
            mulSigned = m[i].sgn; rdat1 = m[i].a; rdat2 = m[i].b;
            aluOp = 4'd3; mulEn = 1'b1; ihit = 1'b1;
            #1;
            cyc = 0;
            while (busy === 1'b1 && cyc < 40) begin
                cyc++;
                // Operands change mid-multiply; the captured values must be used
                if (cyc == 6) begin rdat1 = 32'h55; rdat2 = 32'h99; end
                tick();
            end
            n_chk++; if (cyc != 33) $display("FAIL mul%0d_busy_cycles got=%0d exp=33", i, cyc); else n_pass++;
            n_chk++; if (ALUOut_next === m[i].exp) $display("FAIL mul%0d_early_latch got=%h", i, ALUOut_next); else n_pass++;
            mulEn = 1'b0;
            tick();
            n_chk++; if (ALUOut_next !== m[i].exp) $display("FAIL mul%0d_product got=%h exp=%h", i, ALUOut_next, m[i].exp); else n_pass++;
            n_chk++; if (busy !== 1'b0) $display("FAIL mul%0d_busy_after got=%b exp=0", i, busy); else n_pass++;
        end
        ihit = 1'b0; mulSigned = 1'b0;
    endtask

    task automatic test_flush();
        rdat1 = 32'd3; rdat2 = 32'd4; aluOp = 4'd3; regDst = 5'd8; regWr = 1'b1; ihit = 1'b1;
        tick();
        n_chk++; if (ALUOut_next !== 32'd7) $display("FAIL flush_pre got=%h exp=7", ALUOut_next); else n_pass++;
        rdat1 = 32'd9; rdat2 = 32'd9; mulEn = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) tick();
        n_chk++; if (busy !== 1'b1) $display("FAIL flush_midmul_busy got=%b exp=1", busy); else n_pass++;
        flush = 1'b1; mulEn = 1'b0;
        tick();
        flush = 1'b0;
        n_chk++; if (ALUOut_next !== 32'd0 || regDst_next !== 5'd0 || regWr_next !== 1'b0 || dmemstore_next !== 32'd0)
            $display("FAIL flush_clear alu=%h dst=%0d wr=%b st=%h", ALUOut_next, regDst_next, regWr_next, dmemstore_next); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL flush_busy got=%b exp=0", busy); else n_pass++;
        rdat1 = 32'd20; rdat2 = 32'd22; ihit = 1'b1;
        tick();
        n_chk++; if (ALUOut_next !== 32'd42 || regDst_next !== 5'd8)
            $display("FAIL flush_after_add alu=%h exp=2a dst=%0d exp=8", ALUOut_next, regDst_next); else n_pass++;
        ihit = 1'b0; regWr = 1'b0;
    endtask

    task automatic test_mem_handshake();
        rdat1 = 32'd100; imm = 32'd4; aluSrc = 1'b1; rdat2 = 32'hAB; aluOp = 4'd3;
        regDst = 5'd9; dREN = 1'b1; dWEN = 1'b0; ihit = 1'b1;
        tick();
        n_chk++; if (ALUOut_next !== 32'd104 || dREN_next !== 1'b1)
            $display("FAIL mem_load alu=%h exp=68 dren=%b exp=1", ALUOut_next, dREN_next); else n_pass++;
        rdat1 = 32'd1; imm = 32'd1; rdat2 = 32'hCD; regDst = 5'd3; dREN = 1'b0; dWEN = 1'b1;
        dhit = 1'b1; ihit = 1'b1;
        tick();
        n_chk++; if (dREN_next !== 1'b0 || dWEN_next !== 1'b0) $display("FAIL mem_dhit_clear dren=%b dwen=%b exp=0", dREN_next, dWEN_next); else n_pass++;
        n_chk++; if (ALUOut_next !== 32'd104 || regDst_next !== 5'd9 || dmemstore_next !== 32'hAB)
            $display("FAIL mem_dhit_hold alu=%h dst=%0d st=%h", ALUOut_next, regDst_next, dmemstore_next); else n_pass++;
        dhit = 1'b0;
        tick();
        n_chk++; if (ALUOut_next !== 32'd2 || regDst_next !== 5'd3 || dWEN_next !== 1'b1 || dmemstore_next !== 32'hCD)
            $display("FAIL mem_next_load alu=%h dst=%0d dwen=%b st=%h", ALUOut_next, regDst_next, dWEN_next, dmemstore_next); else n_pass++;
        ihit = 1'b0; aluSrc = 1'b0; dWEN = 1'b0;
    endtask

    task automatic test_rst_done();
        int cyc;
        rdat1 = 32'd6; rdat2 = 32'd7; mulSigned = 1'b0; mulEn = 1'b1; ihit = 1'b0;
        #1;
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            tick();
        end
        n_chk++; if (cyc != 33) $display("FAIL rst_done_reach got=%0d exp=33", cyc); else n_pass++;
        RST = 1'b1; mulEn = 1'b0;
        tick();
        RST = 1'b0;
        n_chk++; if (ALUOut_next !== 32'd0 || dWEN_next !== 1'b0 || nPC_next !== 32'd0 || busy !== 1'b0)
            $display("FAIL rst_done_clear alu=%h dwen=%b npc=%h busy=%b", ALUOut_next, dWEN_next, nPC_next, busy); else n_pass++;
        rdat1 = 32'hF0; rdat2 = 32'hFF; aluOp = 4'd5; ihit = 1'b1;
        tick();
        n_chk++; if (ALUOut_next !== 32'hF0) $display("FAIL rst_done_no_product got=%h exp=f0", ALUOut_next); else n_pass++;
        ihit = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_alu();
        test_control();
        test_multiply();
        test_flush();
        test_mem_handshake();
        test_rst_done();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/execute.md
# execute

Execute stage and EX/MEM pipeline register of the five-stage pipeline. Computes the ALU result or an iterative 32×32 multiply from decoded operands and latches results and control into the EX/MEM register consumed by the memory stage. Pipeline advance follows the same ihit/dhit/flush discipline as the memory stage. A multi-cycle multiply raises `busy` so the hazard unit stalls fetch and decode.

## Interface
- No parameters; data width fixed at 32.
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous, active-high reset
- ihit, dhit, flush  in  1 each  instruction-hit advance, data-hit completion, pipeline flush
- rdat1, rdat2  in  32  register operands
- imm  in  32  pre-extended immediate
- shamt  in  5  shift amount
- aluSrc  in  1  B = imm when 1, else rdat2
- aluOp  in  4  ALU operation code
- mulEn, mulSigned  in  1 each  multiply request, signed mode
- nPC  in  32  next-PC passthrough
- regWr, regSel  in  1, 2  writeback control passthrough
- regDst  in  5  destination register
- dREN, dWEN  in  1 each  data-memory request
- busy  out  1  multiply in progress; stall request
- ALUOut_next, dmemstore_next, nPC_next  out  32 each  EX/MEM register fields
- regWr_next, regSel_next, regDst_next, dREN_next, dWEN_next  out  1/2/5/1/1  EX/MEM control fields

## Operation
- ALU ops: 0 SLL B<<shamt; 1 SRL B>>shamt (logical); 2 SRA; 3 ADD; 4 SUB; 5 AND; 6 OR; 7 XOR; 8 NOR; 9 SLT signed (result 0/1); 10 SLTU; 11 LUI {B[15:0],16'h0}; 12–15 return 0. Add/sub wrap mod 2^32, no overflow trap.
- Multiplier FSM: IDLE, MUL, DONE.
  - IDLE: mulEn=1 loads |rdat1| and |rdat2| (abs only when mulSigned) and records the sign. It clears the accumulator and count, then goes to MUL.
  - MUL: one radix-2 shift-add step per cycle with a 5-bit count. At count==31 it goes to DONE.
  - DONE: holds the low 32 bits of the product, negated if signs differ. On ihit it returns to IDLE.
- busy = (IDLE && mulEn) || MUL. busy=0 in DONE.
- EX/MEM register update priority, per cycle:
  1. RST or flush: clear every `_next` output to 0. FSM goes to IDLE.
  2. dhit: clear dREN_next and dWEN_next. All other fields hold.
  3. ihit && !busy: load all fields. ALUOut_next gets the product when in DONE, else the ALU result. dmemstore_next gets rdat2. Control fields load from their inputs.
  4. Otherwise hold.
- ihit while busy does not update the register. It is the hazard unit's job to hold upstream inputs stable.

## Timing
- Reset: all outputs 0, FSM IDLE, busy = mulEn.
- ALU path: result visible on `_next` in the cycle after the ihit edge (one-cycle latency).
- Multiply: mulEn is seen in IDLE at edge t. MUL runs for edges t+1..t+32. DONE is entered after edge t+32, and busy is high through cycle t+32. The first ihit edge at or after t+33 latches the product. Minimum total is 34 cycles.
- flush or RST during MUL or DONE aborts the multiply. The product is discarded and busy equals mulEn on the next cycle.
- dhit and ihit in the same cycle: dhit wins. The register does not load that edge.
- Operand changes during MUL are ignored, because operands are captured at start.

## Test plan
- Reset then ALU: rdat1=5, rdat2=7, aluOp=ADD, ihit -> ALUOut_next=12 next cycle. With SUB and rdat1=0, rdat2=1 -> 0xFFFFFFFF. SLT with -1 vs 1 -> 1. SLTU with the same operands -> 0.
- Immediate/shift: aluSrc=1, imm=0x00001234, LUI -> 0x12340000. SRA with B=0x80000000, shamt=4 -> 0xF8000000.
- Multiply: mulSigned=1, rdat1=-3, rdat2=7, ihit held high -> busy high 33 cycles, ALUOut_next=0xFFFFFFEB one cycle after DONE. Unsigned 0xFFFFFFFF×2 -> 0xFFFFFFFE.
- Flush at MUL count 10 -> all `_next` = 0, FSM IDLE. A following ADD completes normally.
- Memory handshake: load with dREN=1 latched, then dhit and ihit together -> dREN_next=0, other fields unchanged. Next ihit alone loads the new instruction.
- RST asserted during DONE -> all outputs 0 on next edge. No product is ever latched.
